mpu_load_sequencer: RTL and testbench
=====================================

# mpu_load_sequencer

Streams a vectorized matrix from memory into the MPU register file. Accepts a load command (destination register, matrix dimensions) and a valid/ready element stream in row-major order, and generates the register file's per-element load port: enable, address, row/column location and matrix size. It is the stage directly upstream of the register file load port, and signals command completion to the MPU controller.

## Interface
- No module parameters; dimensions come from `global_defs`: `FP`, `M`, `N`, `MBITS`, `NBITS`, `MATRIX_REG_SIZE`.
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `load_req_in`  in  1  load command request.
- `load_ready_out`  out  1  sequencer idle; command accepted when `load_req_in && load_ready_out`.
- `load_addr_in`  in  `MATRIX_REG_SIZE`  destination register.
- `load_m_in`  in  `MBITS+1`  last row index (rows-1).
- `load_n_in`  in  `NBITS+1`  last column index (cols-1).
- `elem_valid_in`  in  1  element stream valid.
- `elem_ready_out`  out  1  element stream ready.
- `elem_in`  in  `FP`  element data.
- `reg_load_en_out`  out  1  register file write strobe.
- `reg_load_addr_out`  out  `MATRIX_REG_SIZE`  destination register.
- `reg_load_element_out`  out  `FP`  element written.
- `reg_i_load_loc_out`  out  `MBITS+1`  row location.
- `reg_j_load_loc_out`  out  `NBITS+1`  column location.
- `reg_m_size_out`  out  `MBITS+1`  latched last row index.
- `reg_n_size_out`  out  `NBITS+1`  latched last column index.
- `load_complete_out`  out  1  one-cycle pulse: final element written.
- `load_error_out`  out  1  one-cycle pulse: command rejected.

## Operation
- FSM states: `LD_IDLE`, `LD_STREAM`, `LD_DONE`.
- `LD_IDLE`: `load_ready_out=1`, `elem_ready_out=0`. On request: latch addr/m/n, clear i=j=0, go to `LD_STREAM`.
- `LD_STREAM`: `load_ready_out=0`, `elem_ready_out=1`. Each handshake (`elem_valid_in && elem_ready_out`) emits one write at the current (i,j), then advances the indices:
  - if j==n: j=0 and i=i+1;
  - otherwise j=j+1.
  - The handshake at i==m and j==n is the final one; go to `LD_DONE`.
- `LD_DONE`: `load_complete_out=1`, both readies 0; next cycle go to `LD_IDLE`.
- Without a handshake, no write occurs and the indices hold. Gaps in `elem_valid_in` are allowed anywhere.
- `load_req_in` outside `LD_IDLE` is ignored (not queued).
- A 1x1 matrix (m=n=0) gives one write followed by `LD_DONE`.
- `reg_m_size_out` and `reg_n_size_out` hold the latched values until the next accepted command.
- Reset (any state, including mid-stream) returns to `LD_IDLE`. No further writes occur; an already-written partial matrix is left in place.

## Timing
- All outputs are registered.
- Reset values: `load_ready_out=1`; all other outputs 0.
- Element accepted in cycle t -> `reg_load_en_out=1` in cycle t+1, with that element and its (i,j). Strobe width is one cycle per element.
- Final element accepted at t -> final write and `load_complete_out` both in t+1 (the `LD_DONE` cycle). `load_ready_out` returns at t+2.
- Command accepted at t -> `elem_ready_out=1` at t+1.
- Throughput: one element per cycle. An R x C matrix with continuous valid takes R*C+2 cycles from command to ready.

## Configuration
- `MPU_LOAD_BOUNDS_CHECK_EN` defined:
  - A command with `load_m_in > M-1` or `load_n_in > N-1` is rejected.
  - `load_error_out` pulses in the cycle after the request; the FSM stays in `LD_IDLE`, with no writes and no latch update.
- Undefined:
  - `load_error_out` is tied 0.
  - Every command is accepted; out-of-range dimensions are the producer's responsibility (behaviour unspecified).

## Structure
- `mpu_pkg`: `typedef enum logic [1:0] {LD_IDLE, LD_STREAM, LD_DONE} load_state_t`.
- `global_defs`: dimension constants (already present).
- One sub-module, `mpu_index_counter`: row-major (i,j) counter with clear, advance enable, latched bounds, and a `last_out` flag when i==m and j==n.

## Test plan
- 2x3 command (m=1, n=2, addr 2); stream 1.0 through 6.0 with continuous valid -> writes (0,0)=1.0, (0,1)=2.0, (0,2)=3.0, (1,0)=4.0, (1,1)=5.0, (1,2)=6.0 on consecutive cycles; complete pulse coincides with the (1,2) write.
- Same 2x3 command with valid low on alternate cycles -> same six writes, each one cycle after its handshake; no spurious strobes.
- 1x1 command, element 7.5 -> single write at (0,0); complete pulse in that write's cycle; ready restored the next cycle.
- `rst` asserted after 3 of 6 elements -> no further strobes; `load_ready_out=1` and all other outputs 0 the cycle after reset.
- `load_req_in` asserted mid-stream with different addr/m/n -> ignored; the original load completes unchanged.
- With `MPU_LOAD_BOUNDS_CHECK_EN`, request m=M -> `load_error_out` pulses once; no writes; `elem_ready_out` stays 0.

Source files
------------

// File: rtl/global_defs.sv
// Dimension constants shared by the MPU blocks: element width, matrix bounds
// and register-file addressing.
package global_defs;
    localparam int FP              = 32;
    localparam int M               = 4;
    localparam int N               = 4;
    localparam int MBITS           = 2;
    localparam int NBITS           = 2;
    localparam int MATRIX_REG_SIZE = 3;
endpackage

// File: rtl/mpu_pkg.sv
// Shared MPU types.
package mpu_pkg;
    typedef enum logic [1:0] {
        LD_IDLE,
        LD_STREAM,
        LD_DONE
    } load_state_t;
endpackage

// File: rtl/mpu_index_counter.sv
// Row-major (i,j) element counter: clears to (0,0), advances one element per
// enable, and flags when it sits on the final element (i==m, j==n).
module mpu_index_counter
    import global_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [MBITS:0]   m_bound,
    input  logic [NBITS:0]   n_bound,
    output logic [MBITS:0]   i,
    output logic [NBITS:0]   j,
    output logic             last_out
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            i <= '0;
            j <= '0;
        end else if (advance) begin
            if (j == n_bound) begin
                j <= '0;
                i <= i + (MBITS+1)'(1);
            end else begin
                j <= j + (NBITS+1)'(1);
            end
        end
    end

    assign last_out = (i == m_bound) && (j == n_bound);

endmodule

// File: rtl/mpu_load_sequencer.sv
// Streams a row-major matrix into the MPU register file load port.
// Optional feature: define MPU_LOAD_BOUNDS_CHECK_EN to reject oversized commands.
module mpu_load_sequencer
    import global_defs::*;
    import mpu_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_req_in,
    output logic                       load_ready_out,
    input  logic [MATRIX_REG_SIZE-1:0] load_addr_in,
    input  logic [MBITS:0]             load_m_in,
    input  logic [NBITS:0]             load_n_in,
    input  logic                       elem_valid_in,
    output logic                       elem_ready_out,
    input  logic [FP-1:0]              elem_in,
    output logic                       reg_load_en_out,
    output logic [MATRIX_REG_SIZE-1:0] reg_load_addr_out,
    output logic [FP-1:0]              reg_load_element_out,
    output logic [MBITS:0]             reg_i_load_loc_out,
    output logic [NBITS:0]             reg_j_load_loc_out,
    output logic [MBITS:0]             reg_m_size_out,
    output logic [NBITS:0]             reg_n_size_out,
    output logic                       load_complete_out,
    output logic                       load_error_out
);

    load_state_t      state_q, state_d;
    logic             accept, reject, handshake, last;
    logic [MBITS:0]   i_cur;
    logic [NBITS:0]   j_cur;

`ifdef MPU_LOAD_BOUNDS_CHECK_EN
    logic out_of_range;
    assign out_of_range = (load_m_in > (MBITS+1)'(M-1)) || (load_n_in > (NBITS+1)'(N-1));
    assign accept       = load_req_in && load_ready_out && !out_of_range;
    assign reject       = load_req_in && load_ready_out && out_of_range;
`else
    assign accept       = load_req_in && load_ready_out;
    assign reject       = 1'b0;
`endif

    assign handshake = elem_valid_in && elem_ready_out;

    mpu_index_counter u_index (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .advance  (handshake),
        .m_bound  (reg_m_size_out),
        .n_bound  (reg_n_size_out),
        .i        (i_cur),
        .j        (j_cur),
        .last_out (last)
    );

    // NOTE: next state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_IDLE:   if (accept) state_d = LD_STREAM;
            LD_STREAM: if (handshake && last) state_d = LD_DONE;
            LD_DONE:   state_d = LD_IDLE;
            default:   state_d = LD_IDLE;
        endcase
    end

    // Readies are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q              <= LD_IDLE;
            load_ready_out       <= 1'b1;
            elem_ready_out       <= 1'b0;
            reg_load_en_out      <= 1'b0;
            reg_load_addr_out    <= '0;
            reg_load_element_out <= '0;
            reg_i_load_loc_out   <= '0;
            reg_j_load_loc_out   <= '0;
            reg_m_size_out       <= '0;
            reg_n_size_out       <= '0;
            load_complete_out    <= 1'b0;
            load_error_out       <= 1'b0;
        end else begin
            state_q           <= state_d;
            load_ready_out    <= (state_d == LD_IDLE);
            elem_ready_out    <= (state_d == LD_STREAM);
            reg_load_en_out   <= handshake;
            load_complete_out <= handshake && last;
            load_error_out    <= reject;
            if (accept) begin
                reg_load_addr_out <= load_addr_in;
                reg_m_size_out    <= load_m_in;
                reg_n_size_out    <= load_n_in;
            end
            if (handshake) begin
                reg_load_element_out <= elem_in;
                reg_i_load_loc_out   <= i_cur;
                reg_j_load_loc_out   <= j_cur;
            end
        end
    end

endmodule

// File: tb/tb_mpu_load_sequencer.sv
// Scoreboard bench for mpu_load_sequencer: expected writes are queued at each
// handshake and matched against writes captured from the load port.
module tb_mpu_load_sequencer;
    import global_defs::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       load_req_in;
    logic                       load_ready_out;
    logic [MATRIX_REG_SIZE-1:0] load_addr_in;
    logic [MBITS:0]             load_m_in;
    logic [NBITS:0]             load_n_in;
    logic                       elem_valid_in;
    logic                       elem_ready_out;
    logic [FP-1:0]              elem_in;
    logic                       reg_load_en_out;
    logic [MATRIX_REG_SIZE-1:0] reg_load_addr_out;
    logic [FP-1:0]              reg_load_element_out;
    logic [MBITS:0]             reg_i_load_loc_out;
    logic [NBITS:0]             reg_j_load_loc_out;
    logic [MBITS:0]             reg_m_size_out;
    logic [NBITS:0]             reg_n_size_out;
    logic                       load_complete_out;
    logic                       load_error_out;

    mpu_load_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .load_req_in          (load_req_in),
        .load_ready_out       (load_ready_out),
        .load_addr_in         (load_addr_in),
        .load_m_in            (load_m_in),
        .load_n_in            (load_n_in),
        .elem_valid_in        (elem_valid_in),
        .elem_ready_out       (elem_ready_out),
        .elem_in              (elem_in),
        .reg_load_en_out      (reg_load_en_out),
        .reg_load_addr_out    (reg_load_addr_out),
        .reg_load_element_out (reg_load_element_out),
        .reg_i_load_loc_out   (reg_i_load_loc_out),
        .reg_j_load_loc_out   (reg_j_load_loc_out),
        .reg_m_size_out       (reg_m_size_out),
        .reg_n_size_out       (reg_n_size_out),
        .load_complete_out    (load_complete_out),
        .load_error_out       (load_error_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [MBITS:0]             i;
        logic [NBITS:0]             j;
        logic [FP-1:0]              d;
        logic [MATRIX_REG_SIZE-1:0] a;
        logic                       c;
        logic [31:0]                cy;
    } wr_t;

    localparam int RW = 3 + MATRIX_REG_SIZE + FP + 2*(MBITS+1) + 2*(NBITS+1) + 2;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  cyc    = 0;
    int  checks = 0;
    int  passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every strobe or completion pulse, tagged with its cycle.
    always @(posedge clk) begin
        #1;
        if (reg_load_en_out || load_complete_out)
            obs_q.push_back('{i: reg_i_load_loc_out, j: reg_j_load_loc_out,
                              d: reg_load_element_out, a: reg_load_addr_out,
                              c: load_complete_out, cy: 32'(cyc)});
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [RW-1:0] out_vec();
        return {load_ready_out, elem_ready_out, reg_load_en_out, reg_load_addr_out,
                reg_load_element_out, reg_i_load_loc_out, reg_j_load_loc_out,
                reg_m_size_out, reg_n_size_out, load_complete_out, load_error_out};
    endfunction

    // All drivers run in the phase 1 time unit after a rising edge.
    task automatic send_cmd(input logic [MATRIX_REG_SIZE-1:0] a, input int m, input int n,
                            output int acc_cyc);
        int budget = 50;
        load_req_in  = 1'b1;
        load_addr_in = a;
        load_m_in    = (MBITS+1)'(m);
        load_n_in    = (NBITS+1)'(n);
        while (!load_ready_out && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        load_req_in = 1'b0;
        if (budget == 0) begin
            checks++;
            $display("FAIL cmd_timeout load_ready_out never rose");
        end
    endtask

    task automatic send_elems(input logic [FP-1:0] d[$], input int m, input int n,
                              input logic [MATRIX_REG_SIZE-1:0] a, input bit gap,
                              output int last_hs);
        int  k      = 0;
        int  budget = 200;
        int  total  = (m + 1) * (n + 1);
        bit  ph     = 1'b0;
        last_hs = 0;
        while (k < d.size() && budget > 0) begin
            elem_valid_in = gap ? ph : 1'b1;
            elem_in       = elem_valid_in ? d[k] : $urandom;
            if (elem_valid_in && elem_ready_out) begin
                exp_q.push_back('{i: (MBITS+1)'(k / (n + 1)), j: (NBITS+1)'(k % (n + 1)),
                                  d: d[k], a: a, c: (k == total - 1), cy: 32'(cyc + 1)});
                last_hs = cyc;
                k++;
            end
            @(posedge clk); #1;
            ph = ~ph;
            budget--;
        end
        elem_valid_in = 1'b0;
        if (budget == 0) begin
            checks++;
            $display("FAIL elem_timeout only %0d of %0d elements accepted", k, d.size());
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_vec() !== {1'b1, (RW-1)'(0)})
            $display("FAIL reset_outputs got %h want %h", out_vec(), {1'b1, (RW-1)'(0)});
        else passes++;
    endtask

    task automatic test_basic();
        logic [FP-1:0] d[$] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000, 32'h40C00000};
        int acc, last;
        wr_t e, o;
        send_cmd(3'd2, 1, 2, acc);
        checks++;
        if (elem_ready_out !== 1'b1 || load_ready_out !== 1'b0)
            $display("FAIL basic_cmd_ready got er=%b lr=%b want er=1 lr=0", elem_ready_out, load_ready_out);
        else passes++;
        send_elems(d, 1, 2, 3'd2, 1'b0, last);
        checks++;
        if (load_complete_out !== 1'b1 || load_ready_out !== 1'b0 || elem_ready_out !== 1'b0)
            $display("FAIL basic_done got c=%b lr=%b er=%b want 1 0 0", load_complete_out, load_ready_out, elem_ready_out);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (load_ready_out !== 1'b1 || load_complete_out !== 1'b0 || cyc != acc + 7)
            $display("FAIL basic_ready_back got lr=%b c=%b at %0d want 1 0 at %0d", load_ready_out, load_complete_out, cyc, acc + 7);
        else passes++;
        checks++;
        if (reg_m_size_out !== 3'd1 || reg_n_size_out !== 3'd2 || load_error_out !== 1'b0)
            $display("FAIL basic_sizes got m=%0d n=%0d err=%b want 1 2 0", reg_m_size_out, reg_n_size_out, load_error_out);
        else passes++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) $display("FAIL basic_write got %h want %h", o, e); else passes++;
        end
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0)
            $display("FAIL basic_count got %0d extra, %0d missing", obs_q.size(), exp_q.size());
        else passes++;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_gaps();
        logic [FP-1:0] d[$] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000, 32'h40C00000};
        int acc, last;
        wr_t e, o;
        send_cmd(3'd2, 1, 2, acc);
        send_elems(d, 1, 2, 3'd2, 1'b1, last);
        repeat (3) @(posedge clk);
        #1;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) $display("FAIL gaps_write got %h want %h", o, e); else passes++;
        end
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0)
            $display("FAIL gaps_count got %0d extra, %0d missing", obs_q.size(), exp_q.size());
        else passes++;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_one_by_one();
        logic [FP-1:0] d[$] = '{32'h40F00000};
        int acc, last;
        wr_t e, o;
        send_cmd(3'd1, 0, 0, acc);
        send_elems(d, 0, 0, 3'd1, 1'b0, last);
        checks++;
        if (load_complete_out !== 1'b1 || reg_load_en_out !== 1'b1 || load_ready_out !== 1'b0)
            $display("FAIL one_done got c=%b en=%b lr=%b want 1 1 0", load_complete_out, reg_load_en_out, load_ready_out);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (load_ready_out !== 1'b1 || reg_load_en_out !== 1'b0)
            $display("FAIL one_ready got lr=%b en=%b want 1 0", load_ready_out, reg_load_en_out);
        else passes++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) $display("FAIL one_write got %h want %h", o, e); else passes++;
        end
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0)
            $display("FAIL one_count got %0d extra, %0d missing", obs_q.size(), exp_q.size());
        else passes++;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_ignore_req();
        logic [FP-1:0] d[$] = '{32'h11111111, 32'h22222222, 32'h33333333,
                               32'h44444444, 32'h55555555, 32'h66666666};
        int acc, last;
        wr_t e, o;
        send_cmd(3'd2, 1, 2, acc);
        load_req_in  = 1'b1;
        load_addr_in = 3'd5;
        load_m_in    = 3'd0;
        load_n_in    = 3'd0;
        send_elems(d, 1, 2, 3'd2, 1'b0, last);
        load_req_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (reg_m_size_out !== 3'd1 || reg_n_size_out !== 3'd2 || reg_load_addr_out !== 3'd2 || load_ready_out !== 1'b1)
            $display("FAIL ignore_latch got m=%0d n=%0d a=%0d lr=%b want 1 2 2 1", reg_m_size_out, reg_n_size_out, reg_load_addr_out, load_ready_out);
        else passes++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) $display("FAIL ignore_write got %h want %h", o, e); else passes++;
        end
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0)
            $display("FAIL ignore_count got %0d extra, %0d missing", obs_q.size(), exp_q.size());
        else passes++;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [FP-1:0] d[$] = '{32'hA0000001, 32'hA0000002, 32'hA0000003};
        int acc, last;
        wr_t e, o;
        send_cmd(3'd3, 1, 2, acc);
        send_elems(d, 1, 2, 3'd3, 1'b0, last);
        rst           = 1'b1;
        elem_valid_in = 1'b1;
        elem_in       = 32'hDEADBEEF;
        @(posedge clk); #1;
        checks++;
        if (out_vec() !== {1'b1, (RW-1)'(0)})
            $display("FAIL midreset_outputs got %h want %h", out_vec(), {1'b1, (RW-1)'(0)});
        else passes++;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        elem_valid_in = 1'b0;
        @(posedge clk); #1;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) $display("FAIL midreset_write got %h want %h", o, e); else passes++;
        end
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0)
            $display("FAIL midreset_count got %0d extra, %0d missing", obs_q.size(), exp_q.size());
        else passes++;
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef MPU_LOAD_BOUNDS_CHECK_EN
    task automatic test_bounds();
        logic [MBITS:0] m_before;
        m_before     = reg_m_size_out;
        load_req_in  = 1'b1;
        load_addr_in = 3'd6;
        load_m_in    = (MBITS+1)'(M);
        load_n_in    = 3'd0;
        @(posedge clk); #1;
        load_req_in = 1'b0;
        checks++;
        if (load_error_out !== 1'b1 || elem_ready_out !== 1'b0 || load_ready_out !== 1'b1)
            $display("FAIL bounds_error got err=%b er=%b lr=%b want 1 0 1", load_error_out, elem_ready_out, load_ready_out);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (load_error_out !== 1'b0 || elem_ready_out !== 1'b0 || reg_m_size_out !== m_before || obs_q.size() != 0)
            $display("FAIL bounds_after got err=%b er=%b m=%0d writes=%0d want 0 0 %0d 0",
                     load_error_out, elem_ready_out, reg_m_size_out, obs_q.size(), m_before);
        else passes++;
        obs_q.delete();
    endtask
`endif

    initial begin
        rst           = 1'b1;
        load_req_in   = 1'b0;
        load_addr_in  = '0;
        load_m_in     = '0;
        load_n_in     = '0;
        elem_valid_in = 1'b0;
        elem_in       = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_basic();
        test_gaps();
        test_one_by_one();
        test_ignore_req();
        test_reset_mid();
`ifdef MPU_LOAD_BOUNDS_CHECK_EN
        test_bounds();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
